clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
- Multi-channel, runtime-programmable clock-enable generator, parametrised successor to the single fixed-divisor divider.
- Each of NUM_CH channels divides clk by its own divisor (2..2^DIV_W-1, odd or even) and produces a near-50% divided level plus a one-cycle tick.
- Divisors are reprogrammed through a valid/ready config port and take effect glitch-free at the channel's next period boundary.
- Sits beside peripheral timing logic (UART baud, LED/PWM, sampling strobes) in the single clk domain.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
DIV_W, 8, divisor width; legal divisor range 2..2^DIV_W-1
DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be legal)

Ports:
clk  in  1  system clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
en  in  NUM_CH  per-channel run enable
sync  in  1  one-cycle pulse: restart all enabled channels at phase 0
cfg_valid  in  1  config request
cfg_ready  out  1  config accept (combinational)
cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH))
cfg_div  in  DIV_W  new divisor
cfg_err  out  1  one-cycle pulse: last accepted request was illegal and was dropped
pend  out  NUM_CH  channel has an accepted, not yet applied divisor
clk_out  out  NUM_CH  divided level, registered
tick  out  NUM_CH  one-cycle pulse at each clk_out rising edge, registered

Behaviour:
- Reset (rst=1 at posedge):
  - all cur_div = DEFAULT_DIV; cnt = 0; pend = 0.
  - clk_out, tick and cfg_err are all 0.
  - Reset mid-period discards all pending updates.
- Per channel state:
  - cnt (DIV_W bits); cur_div; nxt_div; pend bit.
  - H = ceil(cur_div/2).
- Counting:
  - Running: en=1 and the channel was running the previous cycle.
  - When running, cnt_next = (cnt == cur_div-1) ? 0 : cnt+1.
  - Registered outputs: clk_out <= (cnt_next < H); tick <= (cnt_next == 0).
  - Period = cur_div cycles; clk_out high H cycles, low cur_div-H cycles.
  - Odd divisors are high one cycle longer than low.
- Enable:
  - en=0: cnt <= 0, clk_out <= 0, tick <= 0.
  - First cycle en=1 after en=0: cnt_next = 0, so clk_out=1 and tick=1 appear on the following cycle (latency 1).
- Config handshake:
  - cfg_ready = !pend[cfg_ch].
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_ch >= NUM_CH or cfg_div < 2: dropped; cfg_err=1 next cycle; pend unchanged.
  - Otherwise: nxt_div <= cfg_div; pend[cfg_ch] <= 1 next cycle.
  - A transfer to a channel whose pend=1 is impossible (ready low); the master must hold.
- Apply (same edge clears pend and loads cur_div = nxt_div):
  - When running and cnt == cur_div-1 (wrap edge); the new period starts with cnt=0 under the new divisor.
  - When en=0 (next edge).
  - When sync=1.
  - The old period always completes, so no truncated or glitched clk_out pulse.
- Simultaneous events:
  - Transfer and apply in the same cycle on the same channel cannot occur: pend=1 blocks the transfer.
  - Transfer on channel A and apply on channel B in the same cycle: both take effect.
- sync:
  - All channels with en=1: cnt_next = 0 (tick=1, clk_out=1 next cycle), applying any pending divisor.
  - sync has priority over the wrap and ordinary counting.
  - Channels with en=0 are unaffected.
- Priority: rst > en=0 > sync > wrap > count.
- Width rules:
  - All compares are unsigned in DIV_W bits.
  - cur_div = 2^DIV_W-1 is legal; cnt never exceeds cur_div-1.

Test Plan:
1. Reset, en=4'b0001, DEFAULT_DIV=2 -> ch0 clk_out toggles 1,0,1,0 from the cycle after en; tick on every clk_out=1 cycle; other channels stay 0.
2. Write ch1 div=5, then en[1]=1 -> clk_out[1] pattern 1,1,1,0,0 repeating; tick[1] once per 5 cycles; pend[1] clears before first tick.
3. ch0 running div=4; at cnt=1 write div=6 -> current period finishes (4 cycles total), then 6-cycle periods (3 high/3 low); pend[0]=1 in between.
4. While pend[2]=1, cfg_valid to ch2 -> cfg_ready=0 until the boundary apply, then accepted; a concurrent write to ch3 is accepted immediately.
5. Write div=1 and cfg_ch=NUM_CH -> cfg_err pulses one cycle each; no pend set; dividers unchanged.
6. Channels at div 3 and 7 out of phase, pulse sync -> both tick together next cycle. Then assert rst mid-period with pend set -> all outputs 0 and pend cleared next cycle; divisors back to DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: per-channel programmable clock-enable generator with glitch-free divisor updates
module clock_divider_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 8,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  logic ch_ok, xfer, good, cfg_err_q;
  // Unmapped channel codes stay ready so the request is accepted and then flagged.
  always_comb begin
    cfg_ready = 1'b1;
    ch_ok = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pend[i];
        ch_ok = 1'b1;
      end
  end
  assign xfer = cfg_valid && cfg_ready;
  assign good = ch_ok && cfg_div >= DIV_W'(2);
  assign cfg_err = cfg_err_q;
  always_ff @(posedge clk) cfg_err_q <= rst ? 1'b0 : xfer && !good;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d, cur_q, cur_d, nxt_q, nxt_d, half;
    logic pend_q, pend_d, run_q, clk_q, tick_q, wrap, apply, ld;
    // A new divisor only lands where a period starts, so no pulse is ever cut short.
    always_comb begin
      wrap = run_q && cnt_q == cur_q - 1'b1;
      apply = pend_q && (!en[c] || sync || wrap);
      cur_d = apply ? nxt_q : cur_q;
      half = (cur_d >> 1) + {{(DIV_W-1){1'b0}}, cur_d[0]};
      cnt_d = (!en[c] || sync || !run_q || wrap) ? '0 : cnt_q + 1'b1;
      ld = xfer && good && cfg_ch == CH_W'(c);
      pend_d = ld || (pend_q && !apply);
      nxt_d = ld ? cfg_div : nxt_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        cur_q <= DIV_W'(DEFAULT_DIV);
        nxt_q <= DIV_W'(DEFAULT_DIV);
        pend_q <= 1'b0;
        run_q <= 1'b0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        cur_q <= cur_d;
        nxt_q <= nxt_d;
        pend_q <= pend_d;
        run_q <= en[c];
        clk_q <= en[c] && cnt_d < half;
        tick_q <= en[c] && cnt_d == '0;
      end
    end
    assign pend[c] = pend_q;
    assign clk_out[c] = clk_q;
    assign tick[c] = tick_q;
  end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: scoreboard bench for clock_divider_multi (5 channels so an out-of-range channel code exists)
module tb_clock_divider_multi;
  localparam int NCH = 5, DW = 8, CW = 3;
  logic clk = 1'b0, rst = 1'b1, sync = 1'b0, cfg_valid = 1'b0;
  logic cfg_ready, cfg_err;
  logic [NCH-1:0] en = '0;
  logic [NCH-1:0] pend, clk_out, tick;
  logic [CW-1:0] cfg_ch = '0;
  logic [DW-1:0] cfg_div = '0;
  typedef struct { string tag; logic [NCH-1:0] c; logic [NCH-1:0] t; logic [NCH-1:0] p; logic e; } exp_t;
  exp_t sb[$];
  exp_t mx;
  logic [NCH-1:0] xc, xt, lxp, len;
  logic lv;
  logic [CW-1:0] lch;
  logic [DW-1:0] ldv;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  clock_divider_multi #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_err(cfg_err), .pend(pend), .clk_out(clk_out), .tick(tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {clk_out, tick} expected k cycles into a run with divisor d
  function automatic logic [1:0] ph(input int d, input int k);
    int m;
    m = k % d;
    return {(m < (d + 1) / 2) ? 1'b1 : 1'b0, (m == 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic set(input int c, input int d, input int k);
    logic [1:0] r;
    r = ph(d, k);
    xc[c] = r[1];
    xt[c] = r[0];
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] e, input logic s, input logic v,
                      input logic [CW-1:0] ch, input logic [DW-1:0] dv,
                      input logic [NCH-1:0] xp, input logic xe, input string tag);
    @(negedge clk);
    rst = r; en = e; sync = s; cfg_valid = v; cfg_ch = ch; cfg_div = dv;
    sb.push_back('{tag, xc, xt, xp, xe});
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      chk({mx.tag, ".clk"}, 32'(clk_out), 32'(mx.c));
      chk({mx.tag, ".tick"}, 32'(tick), 32'(mx.t));
      chk({mx.tag, ".pend"}, 32'(pend), 32'(mx.p));
      chk({mx.tag, ".err"}, 32'(cfg_err), 32'(mx.e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    xc = '0; xt = '0;
    step(1, '0, 0, 0, 3'd0, 8'd0, '0, 0, "rst0");
    step(1, '0, 0, 0, 3'd0, 8'd0, '0, 0, "rst1");
    // default divisor 2 on ch0
    for (int k = 0; k < 4; k++) begin
      xc = '0; xt = '0; set(0, 2, k);
      step(0, 5'b00001, 0, 0, 3'd0, 8'd0, '0, 0, "t1");
    end
    xc = '0; xt = '0;
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t1off");
    // odd divisor 5 on ch1
    step(0, '0, 0, 1, 3'd1, 8'd5, 5'b00010, 0, "t2wr");
    #1 chk("t2rdy", 32'(cfg_ready), 32'(1));
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t2ap");
    for (int k = 0; k < 10; k++) begin
      xc = '0; xt = '0; set(1, 5, k);
      step(0, 5'b00010, 0, 0, 3'd0, 8'd0, '0, 0, "t2run");
    end
    xc = '0; xt = '0;
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t2off");
    // 4 -> 6 mid-period on ch0
    step(0, '0, 0, 1, 3'd0, 8'd4, 5'b00001, 0, "t3wr");
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t3ap");
    for (int k = 0; k < 16; k++) begin
      xc = '0; xt = '0;
      if (k < 4) set(0, 4, k); else set(0, 6, k - 4);
      step(0, 5'b00001, 0, k == 2, 3'd0, 8'd6, (k == 2 || k == 3) ? 5'b00001 : 5'b00000, 0, "t3run");
      if (k == 2) #1 chk("t3rdy", 32'(cfg_ready), 32'(1));
    end
    xc = '0; xt = '0;
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t3off");
    // ready back-pressure on ch2, interleaved write to ch3
    step(0, '0, 0, 1, 3'd2, 8'd3, 5'b00100, 0, "t4wr");
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t4ap");
    for (int k = 0; k < 15; k++) begin
      xc = '0; xt = '0;
      if (k < 3) set(2, 3, k); else if (k < 10) set(2, 7, k - 3); else set(2, 4, k - 10);
      lv = k >= 1 && k <= 4;
      lch = (k == 2) ? 3'd3 : 3'd2;
      ldv = (k == 1) ? 8'd7 : (k == 2) ? 8'd9 : 8'd4;
      lxp = (k == 1) ? 5'b00100 : (k == 2) ? 5'b01100 : (k >= 4 && k <= 9) ? 5'b00100 : 5'b00000;
      step(0, 5'b00100, 0, lv, lch, ldv, lxp, 0, "t4run");
      if (lv) #1 chk("t4rdy", 32'(cfg_ready), (k != 3) ? 32'(1) : 32'(0));
    end
    xc = '0; xt = '0;
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t4off");
    // illegal requests
    step(0, '0, 0, 1, 3'd1, 8'd1, '0, 1, "t5div");
    #1 chk("t5rdy_div", 32'(cfg_ready), 32'(1));
    step(0, '0, 0, 1, 3'd5, 8'd7, '0, 1, "t5ch");
    #1 chk("t5rdy_ch", 32'(cfg_ready), 32'(1));
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t5idle");
    // sync alignment, then reset with a pending update
    step(0, '0, 0, 1, 3'd3, 8'd3, 5'b01000, 0, "t6w3");
    step(0, '0, 0, 1, 3'd4, 8'd7, 5'b10000, 0, "t6w4");
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t6ap");
    for (int n = 0; n < 12; n++) begin
      xc = '0; xt = '0;
      len = (n < 2) ? 5'b01000 : 5'b11010;
      set(3, 3, (n < 6) ? n : n - 6);
      if (n >= 2) begin
        set(1, 5, (n < 6) ? n - 2 : n - 6);
        if (n < 6) set(4, 7, n - 2); else set(4, 5, n - 6);
      end
      lv = n == 4 || n == 10;
      lch = (n == 4) ? 3'd4 : 3'd3;
      ldv = (n == 4) ? 8'd5 : 8'd6;
      lxp = (n == 4 || n == 5) ? 5'b10000 : (n >= 10) ? 5'b01000 : 5'b00000;
      step(0, len, n == 6, lv, lch, ldv, lxp, 0, "t6run");
    end
    xc = '0; xt = '0;
    step(1, 5'b11010, 0, 0, 3'd0, 8'd0, '0, 0, "t6rst");
    for (int k = 0; k < 4; k++) begin
      xc = '0; xt = '0; set(3, 2, k); set(4, 2, k);
      step(0, 5'b11000, 0, 0, 3'd0, 8'd0, '0, 0, "t6def");
    end
    xc = '0; xt = '0;
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t6off");
    // maximum divisor
    step(0, '0, 0, 1, 3'd0, 8'd255, 5'b00001, 0, "t7wr");
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "t7ap");
    for (int k = 0; k < 257; k++) begin
      xc = '0; xt = '0; set(0, 255, k);
      step(0, 5'b00001, 0, 0, 3'd0, 8'd0, '0, 0, "t7run");
    end
    xc = '0; xt = '0;
    step(0, '0, 0, 0, 3'd0, 8'd0, '0, 0, "end");
    @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
